vec_regfile_seq: RTL and testbench

Parametrised next-generation vector register file that accepts whole LMUL register groups through a valid/ready write port. It retires the group into the array one register per cycle under a small FSM. A per-register busy scoreboard lets issue logic detect in-flight destinations. Sits between the vector execute/load units and operand read of the vector pipeline.

---
 rtl/vec_regfile_pkg.sv | 15 +
 rtl/vec_wr_sequencer.sv | 79 +++++++
 rtl/vec_regfile_seq.sv | 64 ++++++
 tb/tb_vec_regfile_seq.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_regfile_pkg.sv
// vec_regfile_pkg: shared defaults, LMUL one-hot encodings and sequencer state type
package vec_regfile_pkg;
  localparam int VLEN_DEF = 128;
  localparam int NUM_REGS_DEF = 32;
  localparam int LMUL_MAX_DEF = 8;
  localparam logic [3:0] LMUL_1 = 4'b0001;
  localparam logic [3:0] LMUL_2 = 4'b0010;
  localparam logic [3:0] LMUL_4 = 4'b0100;
  localparam logic [3:0] LMUL_8 = 4'b1000;
  typedef enum logic {IDLE, WRITE} state_t;
  function automatic logic [3:0] lmul_to_count(input logic [3:0] lmul);
    return lmul == LMUL_1 ? 4'd1 : lmul == LMUL_2 ? 4'd2 :
           lmul == LMUL_4 ? 4'd4 : lmul == LMUL_8 ? 4'd8 : 4'd0;
  endfunction
endpackage

// File: rtl/vec_wr_sequencer.sv
// vec_wr_sequencer: accepts an LMUL group, checks legality and retires it one register per cycle
module vec_wr_sequencer
  import vec_regfile_pkg::*;
#(
  parameter int VLEN = VLEN_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int LMUL_MAX = LMUL_MAX_DEF,
  parameter int ADDR_W = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [3:0]               wr_lmul,
  input  logic [LMUL_MAX*VLEN-1:0] wr_data,
  input  logic                     wr_keep_v0,
  output logic                     wr_done,
  output logic                     wr_err,
  output logic [NUM_REGS-1:0]      busy,
  output logic                     we,
  output logic [ADDR_W-1:0]        waddr,
  output logic [VLEN-1:0]          wdata
);
  state_t state, state_n;
  logic [2:0] beat;
  logic [3:0] cnt, req_cnt;
  logic [ADDR_W-1:0] base;
  logic [LMUL_MAX*VLEN-1:0] data;
  logic keep, accept, legal, last;
  logic [NUM_REGS-1:0] busy_n;

  assign req_cnt = lmul_to_count(wr_lmul);
  assign legal = req_cnt != 4'd0 && int'(req_cnt) <= LMUL_MAX &&
                 (wr_addr & ADDR_W'(req_cnt - 4'd1)) == '0 &&
                 int'(wr_addr) + int'(req_cnt) <= NUM_REGS;
  assign accept = wr_valid && wr_ready;
  assign last = {1'b0, beat} == cnt - 4'd1;
  assign waddr = base + ADDR_W'(beat);
  assign wdata = data[beat*VLEN +: VLEN];

  always_comb begin
    wr_ready = state == IDLE;
    state_n = state == IDLE ? (accept && legal ? WRITE : IDLE) : (last ? IDLE : WRITE);
    // a kept v0 beat still spends its cycle and clears busy[0], it just skips the array write
    we = state == WRITE && !(keep && base == '0 && beat == 3'd0);
    busy_n = busy;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (accept && legal && i >= int'(wr_addr) && i < int'(wr_addr) + int'(req_cnt)) busy_n[i] = 1'b1;
      if (state == WRITE && waddr == ADDR_W'(i)) busy_n[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      beat <= '0;
      cnt <= '0;
      base <= '0;
      data <= '0;
      keep <= 1'b0;
      busy <= '0;
      wr_done <= 1'b0;
      wr_err <= 1'b0;
    end else begin
      state <= state_n;
      busy <= busy_n;
      wr_done <= state == WRITE && last;
      wr_err <= accept && !legal;
      beat <= state == WRITE ? beat + 3'd1 : 3'd0;
      if (accept && legal) begin
        base <= wr_addr;
        cnt <= req_cnt;
        data <= wr_data;
        keep <= wr_keep_v0;
      end
    end
  end
endmodule

// File: rtl/vec_regfile_seq.sv
// vec_regfile_seq: vector register file with sequenced LMUL group writes, mask port and busy scoreboard
module vec_regfile_seq
  import vec_regfile_pkg::*;
#(
  parameter int VLEN = VLEN_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD = 3,
  parameter int LMUL_MAX = LMUL_MAX_DEF,
  parameter int ADDR_W = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*VLEN-1:0]   rd_data,
  output logic [NUM_RD-1:0]        rd_err,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [3:0]               wr_lmul,
  input  logic [LMUL_MAX*VLEN-1:0] wr_data,
  input  logic                     wr_keep_v0,
  output logic                     wr_done,
  output logic                     wr_err,
  input  logic                     mask_wr_en,
  input  logic [VLEN-1:0]          mask_wdata,
  output logic [VLEN-1:0]          v0_mask_data,
  output logic [NUM_REGS-1:0]      busy
);
  logic [VLEN-1:0] regs [NUM_REGS];
  logic we;
  logic [ADDR_W-1:0] waddr;
  logic [VLEN-1:0] wdata;

  vec_wr_sequencer #(
    .VLEN(VLEN), .NUM_REGS(NUM_REGS), .LMUL_MAX(LMUL_MAX), .ADDR_W(ADDR_W)
  ) u_seq (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_lmul(wr_lmul), .wr_data(wr_data), .wr_keep_v0(wr_keep_v0),
    .wr_done(wr_done), .wr_err(wr_err), .busy(busy),
    .we(we), .waddr(waddr), .wdata(wdata)
  );

  // the mask write comes last so it overrides a group beat landing on v0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) if (we && waddr == ADDR_W'(i)) regs[i] <= wdata;
      if (mask_wr_en) regs[0] <= mask_wdata;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_err = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_err[p] = int'(rd_addr[p*ADDR_W +: ADDR_W]) >= NUM_REGS;
      for (int i = 0; i < NUM_REGS; i++)
        if (rd_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(i)) rd_data[p*VLEN +: VLEN] = regs[i];
    end
  end

  assign v0_mask_data = regs[0];
endmodule

// File: tb/tb_vec_regfile_seq.sv
// tb_vec_regfile_seq: directed table and sequence checks of the sequenced vector register file
module tb_vec_regfile_seq;
  localparam int VLEN = 128;
  localparam int NR = 32;
  localparam int NRD = 3;
  localparam int LM = 8;
  localparam int AW = 6;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [NRD*AW-1:0] rd_addr = '0;
  logic [NRD*VLEN-1:0] rd_data;
  logic [NRD-1:0] rd_err;
  logic wr_valid = 1'b0;
  logic wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [3:0] wr_lmul = '0;
  logic [LM*VLEN-1:0] wr_data = '0;
  logic wr_keep_v0 = 1'b0;
  logic wr_done, wr_err;
  logic mask_wr_en = 1'b0;
  logic [VLEN-1:0] mask_wdata = '0;
  logic [VLEN-1:0] v0_mask_data;
  logic [NR-1:0] busy;

  logic [VLEN-1:0] model [NR];
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [3:0] lmul;
    int n;
    logic err;
  } vec_t;
  vec_t vecs [11];

  always #5 clk = ~clk;

  vec_regfile_seq #(.VLEN(VLEN), .NUM_REGS(NR), .NUM_RD(NRD), .LMUL_MAX(LM), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_err(rd_err),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_lmul(wr_lmul),
    .wr_data(wr_data), .wr_keep_v0(wr_keep_v0), .wr_done(wr_done), .wr_err(wr_err),
    .mask_wr_en(mask_wr_en), .mask_wdata(mask_wdata), .v0_mask_data(v0_mask_data), .busy(busy)
  );

  task automatic chk(input string name, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reg(input string name, input int a, input logic [VLEN-1:0] exp);
    rd_addr[AW-1:0] = AW'(a);
    #1;
    chk(name, rd_data[VLEN-1:0], exp);
  endtask

  function automatic logic [VLEN-1:0] slice(input int g, input int k);
    return {4{32'(g * 256 + k) ^ 32'hC0DE_0000}};
  endfunction

  function automatic logic [LM*VLEN-1:0] gdata(input int g);
    logic [LM*VLEN-1:0] d;
    for (int k = 0; k < LM; k++) d[k*VLEN +: VLEN] = slice(g, k);
    return d;
  endfunction

  task automatic send(input int a, input logic [3:0] l, input logic keep, input logic [LM*VLEN-1:0] d);
    wr_valid = 1'b1;
    wr_addr = AW'(a);
    wr_lmul = l;
    wr_keep_v0 = keep;
    wr_data = d;
    tick;
    wr_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int n);
    int cycles = 0;
    while (!wr_done && cycles < 20) begin
      tick;
      cycles++;
    end
    chk(name, VLEN'(cycles), VLEN'(n));
  endtask

  task automatic sweep(input string name);
    for (int i = 0; i < NR; i++) chk_reg($sformatf("%s_v%0d", name, i), i, model[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [LM*VLEN-1:0] d;
    logic [NR-1:0] eb;
    for (int i = 0; i < NR; i++) model[i] = '0;
    vecs[0]  = '{6'd3,  4'b0010, 0, 1'b1};
    vecs[1]  = '{6'd28, 4'b1000, 0, 1'b1};
    vecs[2]  = '{6'd40, 4'b1000, 0, 1'b1};
    vecs[3]  = '{6'd5,  4'b0011, 0, 1'b1};
    vecs[4]  = '{6'd0,  4'b0000, 0, 1'b1};
    vecs[5]  = '{6'd31, 4'b0001, 1, 1'b0};
    vecs[6]  = '{6'd30, 4'b0010, 2, 1'b0};
    vecs[7]  = '{6'd24, 4'b1000, 8, 1'b0};
    vecs[8]  = '{6'd6,  4'b0100, 0, 1'b1};
    vecs[9]  = '{6'd32, 4'b0001, 0, 1'b1};
    vecs[10] = '{6'd16, 4'b0100, 4, 1'b0};

    #12;
    chk("rst_done", VLEN'(wr_done), 0);
    chk("rst_err", VLEN'(wr_err), 0);
    chk("rst_busy", VLEN'(busy), 0);
    chk("rst_v0", v0_mask_data, 0);
    reset = 1'b1;
    tick;
    chk("rst_ready", VLEN'(wr_ready), 1);

    // single register group to v5
    d = '0;
    d[VLEN-1:0] = {16{8'hA5}};
    send(5, 4'b0001, 1'b0, d);
    chk("l1_ready_low", VLEN'(wr_ready), 0);
    chk("l1_busy", VLEN'(busy), VLEN'(32'h20));
    chk_reg("l1_v5_before", 5, 0);
    tick;
    chk("l1_done", VLEN'(wr_done), 1);
    chk("l1_ready_back", VLEN'(wr_ready), 1);
    chk("l1_busy_clr", VLEN'(busy), 0);
    chk_reg("l1_v5", 5, {16{8'hA5}});
    model[5] = {16{8'hA5}};
    tick;
    chk("l1_done_pulse", VLEN'(wr_done), 0);

    // four register group to v8
    d = '0;
    for (int k = 0; k < 4; k++) d[k*VLEN +: VLEN] = VLEN'(k + 1);
    send(8, 4'b0100, 1'b0, d);
    eb = 32'h0F00;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("l4_busy%0d", k), VLEN'(busy), VLEN'(eb));
      chk($sformatf("l4_nodone%0d", k), VLEN'(wr_done), 0);
      eb[8+k] = 1'b0;
      tick;
      chk_reg($sformatf("l4_v%0d", 8 + k), 8 + k, VLEN'(k + 1));
      model[8+k] = VLEN'(k + 1);
    end
    chk("l4_done", VLEN'(wr_done), 1);
    chk("l4_busy_clr", VLEN'(busy), 0);

    // legality table, ok entries issued back-to-back where possible
    for (int i = 0; i < 11; i++) begin
      send(vecs[i].addr, vecs[i].lmul, 1'b0, gdata(i + 10));
      chk($sformatf("t%0d_err", i), VLEN'(wr_err), VLEN'(vecs[i].err));
      chk($sformatf("t%0d_ready", i), VLEN'(wr_ready), VLEN'(vecs[i].err));
      eb = '0;
      for (int k = 0; k < vecs[i].n; k++) eb[int'(vecs[i].addr) + k] = 1'b1;
      chk($sformatf("t%0d_busy", i), VLEN'(busy), VLEN'(eb));
      if (vecs[i].err) begin
        tick;
        chk($sformatf("t%0d_err_pulse", i), VLEN'(wr_err), 0);
        chk($sformatf("t%0d_nodone", i), VLEN'(wr_done), 0);
      end else begin
        wait_done($sformatf("t%0d_lat", i), vecs[i].n);
        chk($sformatf("t%0d_busy_clr", i), VLEN'(busy), 0);
        for (int k = 0; k < vecs[i].n; k++) model[int'(vecs[i].addr) + k] = slice(i + 10, k);
      end
    end

    // preload v0, then LMUL=8 at v0 keeping v0 with a mask write on beat 1
    mask_wr_en = 1'b1;
    mask_wdata = VLEN'(8'h55);
    tick;
    mask_wr_en = 1'b0;
    chk("mask_pre", v0_mask_data, VLEN'(8'h55));
    send(0, 4'b1000, 1'b1, gdata(30));
    chk("keep_busy_all", VLEN'(busy), VLEN'(32'hFF));
    tick;
    chk("keep_v0_held", v0_mask_data, VLEN'(8'h55));
    chk("keep_busy0_clr", VLEN'(busy), VLEN'(32'hFE));
    mask_wr_en = 1'b1;
    mask_wdata = VLEN'(8'hFF);
    tick;
    mask_wr_en = 1'b0;
    chk("keep_v0_mask", v0_mask_data, VLEN'(8'hFF));
    chk("keep_busy1_clr", VLEN'(busy), VLEN'(32'hFC));
    chk_reg("keep_v1", 1, slice(30, 1));
    wait_done("keep_lat", 6);
    chk("keep_busy_done", VLEN'(busy), 0);
    model[0] = VLEN'(8'hFF);
    for (int k = 1; k < 8; k++) model[k] = slice(30, k);
    tick;

    // mask write collides with beat 0 of a v0 group
    send(0, 4'b0010, 1'b0, gdata(31));
    mask_wr_en = 1'b1;
    mask_wdata = VLEN'(16'h1234);
    tick;
    mask_wr_en = 1'b0;
    chk("coll_v0", v0_mask_data, VLEN'(16'h1234));
    chk("coll_busy", VLEN'(busy), VLEN'(32'h2));
    wait_done("coll_lat", 1);
    chk_reg("coll_v1", 1, slice(31, 1));
    model[0] = VLEN'(16'h1234);
    model[1] = slice(31, 1);

    // out-of-range read on port 2 alongside two legal reads
    rd_addr = {6'd40, 6'd31, 6'd0};
    #1;
    chk("rd_err", VLEN'(rd_err), VLEN'(3'b100));
    chk("rd_oor_data", rd_data[2*VLEN +: VLEN], 0);
    chk("rd_p1", rd_data[VLEN +: VLEN], model[31]);
    chk("rd_p0", rd_data[VLEN-1:0], model[0]);
    sweep("sweep1");

    // reset during beat 2 of an LMUL=4 group
    tick;
    send(12, 4'b0100, 1'b0, gdata(40));
    tick;
    tick;
    reset = 1'b0;
    #1;
    chk("arst_busy", VLEN'(busy), 0);
    chk("arst_v0", v0_mask_data, 0);
    chk("arst_done", VLEN'(wr_done), 0);
    chk_reg("arst_v12", 12, 0);
    chk_reg("arst_v13", 13, 0);
    reset = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick;
      chk($sformatf("post_rst_ready%0d", j), VLEN'(wr_ready), 1);
      chk($sformatf("post_rst_nodone%0d", j), VLEN'(wr_done), 0);
    end
    for (int i = 0; i < NR; i++) model[i] = '0;
    sweep("sweep2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
